score_timer_bcd: RTL and testbench
==================================

# score_timer_bcd

Game-side scoring and countdown stage feeding the 4-digit BCD display driver. It keeps a 4-digit BCD hit score and a 2-digit BCD countdown in seconds, and runs the IDLE/RUN/OVER game state machine. Each cycle it presents one selected 8-bit BCD page (time, score high byte, or score low byte) on `score_bcd`, which drives the display driver's `SCORE` input directly.

## Interface
- `GAME_SECONDS`, default 8'h60: game length as two BCD digits, legal range 8'h01–8'h99.
- `clk` in 1: system clock, the same divided clock used by the display driver.
- `rst` in 1: synchronous reset, active low.
- `start` in 1: one-cycle pulse that begins or restarts a game.
- `hit` in 1: one-cycle pulse for a successful whack.
- `tick_1hz` in 1: one-cycle pulse, once per second.
- `page_tick` in 1: one-cycle pulse that advances the display page.
- `score_bcd` out 8: selected page as {tens digit, units digit} BCD; connects to the display `SCORE` input.
- `page` out 2: current page (0 = time, 1 = score[15:8], 2 = score[7:0]).
- `game_active` out 1: high in RUN.
- `game_over` out 1: high in OVER.

## Operation
- Reset (sampled at a `clk` edge with `rst`=0) sets:
  - state IDLE, score 16'h0000, time `GAME_SECONDS`, page 0;
  - `score_bcd` 8'h00, `game_active` 0, `game_over` 0.
- IDLE:
  - score and time are held; `hit` and `tick_1hz` are ignored.
  - `start` loads score 0000 and time `GAME_SECONDS`, then moves to RUN.
- RUN:
  - `hit` increments score by 1 in BCD with a carry chain across all 4 digits.
  - Score saturates at 16'h9999; further hits leave it at 9999.
  - `tick_1hz` decrements time by 1 in BCD (units borrow from tens, 8'h10 becomes 8'h09).
  - When a tick takes time from 8'h01 to 8'h00, the next state is OVER.
  - `start` is ignored.
- OVER:
  - score and time (00) are frozen; `hit` and `tick_1hz` are ignored.
  - `start` reloads as in IDLE and moves to RUN.
- Simultaneous events:
  - `hit` and the final `tick_1hz` in the same RUN cycle: the hit is counted and the state still goes to OVER.
  - `start` and `hit` in the same IDLE/OVER cycle: start wins and the hit is dropped (score = 0000).
  - `page_tick` is independent of state and acts concurrently with all other events.
- Page sequence 0→1→2→0. Each `page_tick` advances one step; page 3 never occurs.
- `score_bcd` selects by page: 0 gives time, 1 gives score[15:8], 2 gives score[7:0].
- Every digit register holds only values 0–9 at all times.

## Timing
- All state is updated on the rising `clk` edge; there are no combinational input-to-output paths.
- `score_bcd` is registered, with 1-cycle latency from any change in score, time or page.
  - Example: a `hit` at edge N updates the score at edge N; `score_bcd` reflects it at edge N+1.
- `game_active` and `game_over` are decoded from the state register and change on the same edge as the state.
- Reset during RUN aborts the game immediately; the reset values above take effect on that edge.

## Structure
- Shared package `whack_pkg` holds:
  - state enum `{ST_IDLE, ST_RUN, ST_OVER}`;
  - page constants `PG_TIME=0`, `PG_SC_HI=1`, `PG_SC_LO=2`;
  - `BCD_MAX_DIGIT=4'd9`.
- Sub-module `bcd_digit`, one BCD digit with:
  - inputs `inc`, `dec`, `load`, `load_val`;
  - outputs `carry_out`, `borrow_out`.
- Instantiate `bcd_digit` 4× for the score (increment only) and 2× for the time (decrement only).
- Saturation detect (score == 9999) sits at the top level and gates `inc` into the score chain.

## Test plan
- Reset, then `start`: `game_active`=1, time 8'h60, score 0000; `score_bcd`=8'h60 on page 0 one cycle later.
- In RUN, 10 `hit` pulses then two `page_tick`: page=2 and `score_bcd`=8'h10; further carries give 0099 + 1 hit = 0100, so page 1 reads 8'h01.
- Preload score 9998 via hits, then 3 more hits: score holds 9999; page 1 reads 8'h99 and page 2 reads 8'h99.
- `GAME_SECONDS`=8'h11, issue 11 `tick_1hz`:
  - time passes 11→10→09 with the borrow;
  - `game_over`=1 after the 11th tick;
  - a `hit` on the 11th tick is counted, and later hits are ignored.
- In OVER, `start` and `hit` in the same cycle: RUN, score 0000, time reloaded.
- Assert `rst` mid-RUN with score 0042: next edge gives IDLE, score 0000, page 0, `score_bcd`=8'h00.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole scoring/timer stage.
// Holds the game state encoding, display page codes and BCD digit helpers.
package whack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  localparam logic [1:0] PG_TIME  = 2'd0;
  localparam logic [1:0] PG_SC_HI = 2'd1;
  localparam logic [1:0] PG_SC_LO = 2'd2;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Forces any out-of-range nibble back into the legal 0-9 digit range.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    logic [3:0] r;
    if (d > BCD_MAX_DIGIT) begin
      r = BCD_MAX_DIGIT;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Page rotation 0 -> 1 -> 2 -> 0; the unused code 3 recovers to 0.
  function automatic logic [1:0] page_advance(input logic [1:0] pg);
    logic [1:0] r;
    case (pg)
      PG_TIME:  r = PG_SC_HI;
      PG_SC_HI: r = PG_SC_LO;
      PG_SC_LO: r = PG_TIME;
      default:  r = PG_TIME;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with increment/decrement and ripple carry/borrow.
// carry_out/borrow_out are combinational so a chain of digits settles in one cycle.
module bcd_digit
  import whack_pkg::*;
#(
  parameter logic [3:0] RESET_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       carry_out,
  output logic       borrow_out
);

  assign carry_out  = inc && (value == BCD_MAX_DIGIT);
  assign borrow_out = dec && (value == 4'd0);

  // Digit register: reset, then load, then increment, then decrement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= bcd_clamp(RESET_VAL);
    end else if (load) begin
      value <= bcd_clamp(load_val);
    end else if (inc) begin
      value <= carry_out ? 4'd0 : (value + 4'd1);
    end else if (dec) begin
      value <= borrow_out ? BCD_MAX_DIGIT : (value - 4'd1);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/score_timer_bcd.sv
// Game score (4 BCD digits) and countdown (2 BCD digits) with IDLE/RUN/OVER control.
// Presents one registered BCD page per cycle for the display driver.
module score_timer_bcd
  import whack_pkg::*;
#(
  parameter logic [7:0] GAME_SECONDS = 8'h60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       tick_1hz,
  input  logic       page_tick,
  output logic [7:0] score_bcd,
  output logic [1:0] page,
  output logic       game_active,
  output logic       game_over
);

  localparam logic [3:0] GS_HI = GAME_SECONDS[7:4];
  localparam logic [3:0] GS_LO = GAME_SECONDS[3:0];

  game_state_e state;
  game_state_e state_next;

  logic [15:0] score;
  logic [7:0]  game_time;
  logic        score_sat;
  logic        score_inc;
  logic        time_dec;
  logic        reload;
  logic        last_tick;
  logic [4:0]  sc_carry;
  logic [3:0]  sc_borrow;
  logic [2:0]  tm_borrow;
  logic [1:0]  tm_carry;
  logic        unused_chain;

  assign score_sat = (score == 16'h9999);
  assign reload    = start && ((state == ST_IDLE) || (state == ST_OVER));
  assign score_inc = (state == ST_RUN) && hit && !score_sat;
  assign time_dec  = (state == ST_RUN) && tick_1hz && (game_time != 8'h00);
  assign last_tick = (state == ST_RUN) && tick_1hz && (game_time == 8'h01);

  assign sc_carry[0]  = score_inc;
  assign tm_borrow[0] = time_dec;

  // Chain ends and the fixed-direction side outputs are not needed downstream.
  assign unused_chain = ^{sc_carry[4], sc_borrow, tm_borrow[2], tm_carry};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_score
      bcd_digit #(.RESET_VAL(4'd0)) u_digit (
        .clk        (clk),
        .rst        (rst),
        .inc        (sc_carry[gi]),
        .dec        (1'b0),
        .load       (reload),
        .load_val   (4'd0),
        .value      (score[4*gi +: 4]),
        .carry_out  (sc_carry[gi+1]),
        .borrow_out (sc_borrow[gi])
      );
    end
  endgenerate

  bcd_digit #(.RESET_VAL(GS_LO)) u_time_lo (
    .clk        (clk),
    .rst        (rst),
    .inc        (1'b0),
    .dec        (tm_borrow[0]),
    .load       (reload),
    .load_val   (GS_LO),
    .value      (game_time[3:0]),
    .carry_out  (tm_carry[0]),
    .borrow_out (tm_borrow[1])
  );

  bcd_digit #(.RESET_VAL(GS_HI)) u_time_hi (
    .clk        (clk),
    .rst        (rst),
    .inc        (1'b0),
    .dec        (tm_borrow[1]),
    .load       (reload),
    .load_val   (GS_HI),
    .value      (game_time[7:4]),
    .carry_out  (tm_carry[1]),
    .borrow_out (tm_borrow[2])
  );

  // Next-state logic for the game controller.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_tick) begin
          state_next = ST_OVER;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_OVER;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register with status flags registered alongside it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      game_active <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_next;
      game_active <= (state_next == ST_RUN);
      game_over   <= (state_next == ST_OVER);
    end
  end

  // Display page rotation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      page <= PG_TIME;
    end else if (page_tick) begin
      page <= page_advance(page);
    end else begin
      page <= page;
    end
  end

  // Registered page mux toward the display driver.
  always_ff @(posedge clk) begin
    if (!rst) begin
      score_bcd <= 8'h00;
    end else begin
      case (page)
        PG_TIME:  score_bcd <= game_time;
        PG_SC_HI: score_bcd <= score[15:8];
        PG_SC_LO: score_bcd <= score[7:0];
        default:  score_bcd <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_score_timer_bcd.sv
// Directed bench for score_timer_bcd: two instances (60 s and 11 s games) share stimulus.
module tb_score_timer_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       page_tick = 1'b0;
  logic [7:0] score_bcd, score_bcd11;
  logic [1:0] page, page11;
  logic       game_active, game_over, game_active11, game_over11;
  logic [7:0] v;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  score_timer_bcd #(.GAME_SECONDS(8'h60)) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .tick_1hz(tick_1hz),
    .page_tick(page_tick), .score_bcd(score_bcd), .page(page),
    .game_active(game_active), .game_over(game_over)
  );

  score_timer_bcd #(.GAME_SECONDS(8'h11)) dut11 (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .tick_1hz(tick_1hz),
    .page_tick(page_tick), .score_bcd(score_bcd11), .page(page11),
    .game_active(game_active11), .game_over(game_over11)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; hit = 1'b0; tick_1hz = 1'b0; page_tick = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic hits(input int n);
    hit = 1'b1;
    for (int i = 0; i < n; i++) step();
    hit = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick_1hz = 1'b1;
    for (int i = 0; i < n; i++) step();
    tick_1hz = 1'b0;
  endtask

  // Rotate to the wanted page (at most 3 steps), then wait for the registered mux.
  task automatic read_page(input bit use11, input logic [1:0] pg, output logic [7:0] val);
    int guard;
    guard = 0;
    while (page !== pg && guard < 3) begin
      page_tick = 1'b1; step(); page_tick = 1'b0;
      guard++;
    end
    checks++;
    if (page !== pg) begin
      failures++;
      $display("FAIL page_reach got=%0d exp=%0d", page, pg);
    end
    step();
    val = use11 ? score_bcd11 : score_bcd;
  endtask

  task automatic test_reset();
    hit = 1'b1; tick_1hz = 1'b1; page_tick = 1'b1; step();
    do_reset();
    checks++; if (page !== 2'd0) begin failures++; $display("FAIL rst_page got=%0d exp=0", page); end
    checks++; if (score_bcd !== 8'h00) begin failures++; $display("FAIL rst_bcd got=%h exp=00", score_bcd); end
    checks++; if (game_active !== 1'b0) begin failures++; $display("FAIL rst_active got=%b exp=0", game_active); end
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL rst_over got=%b exp=0", game_over); end
    checks++; if (score_bcd11 !== 8'h00) begin failures++; $display("FAIL rst_bcd11 got=%h exp=00", score_bcd11); end
  endtask

  task automatic test_idle_ignore();
    hits(3); ticks(2);
    read_page(1'b0, 2'd0, v);
    checks++; if (v !== 8'h60) begin failures++; $display("FAIL idle_time got=%h exp=60", v); end
    read_page(1'b0, 2'd2, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL idle_score got=%h exp=00", v); end
    checks++; if (game_active !== 1'b0) begin failures++; $display("FAIL idle_active got=%b exp=0", game_active); end
  endtask

  task automatic test_start();
    do_reset();
    pulse_start();
    checks++; if (game_active !== 1'b1) begin failures++; $display("FAIL start_active got=%b exp=1", game_active); end
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL start_over got=%b exp=0", game_over); end
    step();
    checks++; if (score_bcd !== 8'h60) begin failures++; $display("FAIL start_time got=%h exp=60", score_bcd); end
    read_page(1'b0, 2'd2, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL start_score got=%h exp=00", v); end
  endtask

  task automatic test_hits();
    do_reset();
    pulse_start();
    hits(10);
    page_tick = 1'b1; step(); step(); page_tick = 1'b0;
    checks++; if (page !== 2'd2) begin failures++; $display("FAIL hits_page got=%0d exp=2", page); end
    step();
    checks++; if (score_bcd !== 8'h10) begin failures++; $display("FAIL hits_10 got=%h exp=10", score_bcd); end
    hits(89);
    read_page(1'b0, 2'd2, v);
    checks++; if (v !== 8'h99) begin failures++; $display("FAIL hits_99 got=%h exp=99", v); end
    hits(1);
    read_page(1'b0, 2'd1, v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL hits_100_hi got=%h exp=01", v); end
    read_page(1'b0, 2'd2, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL hits_100_lo got=%h exp=00", v); end
  endtask

  task automatic test_saturation();
    hits(9898);
    read_page(1'b0, 2'd1, v);
    checks++; if (v !== 8'h99) begin failures++; $display("FAIL sat_9998_hi got=%h exp=99", v); end
    read_page(1'b0, 2'd2, v);
    checks++; if (v !== 8'h98) begin failures++; $display("FAIL sat_9998_lo got=%h exp=98", v); end
    hits(3);
    read_page(1'b0, 2'd1, v);
    checks++; if (v !== 8'h99) begin failures++; $display("FAIL sat_hi got=%h exp=99", v); end
    read_page(1'b0, 2'd2, v);
    checks++; if (v !== 8'h99) begin failures++; $display("FAIL sat_lo got=%h exp=99", v); end
    checks++; if (game_active !== 1'b1) begin failures++; $display("FAIL sat_active got=%b exp=1", game_active); end
  endtask

  task automatic test_countdown();
    do_reset();
    pulse_start();
    ticks(1);
    read_page(1'b1, 2'd0, v);
    checks++; if (v !== 8'h10) begin failures++; $display("FAIL cd_10 got=%h exp=10", v); end
    ticks(1);
    read_page(1'b1, 2'd0, v);
    checks++; if (v !== 8'h09) begin failures++; $display("FAIL cd_borrow got=%h exp=09", v); end
    ticks(8);
    read_page(1'b1, 2'd0, v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL cd_01 got=%h exp=01", v); end
    checks++; if (game_over11 !== 1'b0) begin failures++; $display("FAIL cd_early_over got=%b exp=0", game_over11); end
    hit = 1'b1; tick_1hz = 1'b1; step(); hit = 1'b0; tick_1hz = 1'b0;
    checks++; if (game_over11 !== 1'b1) begin failures++; $display("FAIL cd_over got=%b exp=1", game_over11); end
    checks++; if (game_active11 !== 1'b0) begin failures++; $display("FAIL cd_active got=%b exp=0", game_active11); end
    hits(3); ticks(2);
    read_page(1'b1, 2'd0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL cd_time00 got=%h exp=00", v); end
    read_page(1'b1, 2'd2, v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL cd_final_hit got=%h exp=01", v); end
    checks++; if (game_over11 !== 1'b1) begin failures++; $display("FAIL cd_hold_over got=%b exp=1", game_over11); end
  endtask

  task automatic test_over_restart();
    start = 1'b1; hit = 1'b1; step(); start = 1'b0; hit = 1'b0;
    checks++; if (game_active11 !== 1'b1) begin failures++; $display("FAIL rs_active got=%b exp=1", game_active11); end
    checks++; if (game_over11 !== 1'b0) begin failures++; $display("FAIL rs_over got=%b exp=0", game_over11); end
    read_page(1'b1, 2'd2, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL rs_score got=%h exp=00", v); end
    read_page(1'b1, 2'd0, v);
    checks++; if (v !== 8'h11) begin failures++; $display("FAIL rs_time got=%h exp=11", v); end
  endtask

  task automatic test_rst_mid_run();
    do_reset();
    pulse_start();
    hits(42);
    read_page(1'b0, 2'd2, v);
    checks++; if (v !== 8'h42) begin failures++; $display("FAIL mr_score got=%h exp=42", v); end
    rst = 1'b0; step();
    checks++; if (game_active !== 1'b0) begin failures++; $display("FAIL mr_active got=%b exp=0", game_active); end
    checks++; if (page !== 2'd0) begin failures++; $display("FAIL mr_page got=%0d exp=0", page); end
    checks++; if (score_bcd !== 8'h00) begin failures++; $display("FAIL mr_bcd got=%h exp=00", score_bcd); end
    rst = 1'b1;
    read_page(1'b0, 2'd2, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL mr_score0 got=%h exp=00", v); end
    read_page(1'b0, 2'd0, v);
    checks++; if (v !== 8'h60) begin failures++; $display("FAIL mr_time got=%h exp=60", v); end
  endtask

  task automatic test_page_wrap();
    do_reset();
    pulse_start();
    page_tick = 1'b1; hit = 1'b1;
    step();
    checks++; if (page !== 2'd1) begin failures++; $display("FAIL pw_1 got=%0d exp=1", page); end
    step();
    checks++; if (page !== 2'd2) begin failures++; $display("FAIL pw_2 got=%0d exp=2", page); end
    step();
    checks++; if (page !== 2'd0) begin failures++; $display("FAIL pw_0 got=%0d exp=0", page); end
    page_tick = 1'b0; hit = 1'b0;
    read_page(1'b0, 2'd2, v);
    checks++; if (v !== 8'h03) begin failures++; $display("FAIL pw_score got=%h exp=03", v); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_start();
    test_hits();
    test_saturation();
    test_countdown();
    test_over_restart();
    test_rst_mid_run();
    test_page_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
